// File: rtl/pipelined_prefix_adder.sv
// Brent-Kung prefix adder/subtractor with a valid/ready pipeline.
// Register banks every REG_EVERY prefix levels; outputs come from the last bank.
module pipelined_prefix_adder #(
   parameter int WIDTH     = 32,
   parameter int REG_EVERY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int LG      = $clog2(WIDTH);
   localparam int LEVELS  = 2*LG - 1;
   localparam int LATENCY = (LEVELS + REG_EVERY - 1) / REG_EVERY + 1;

   logic             w_adv;
   logic [WIDTH-1:0] w_bx;
   logic [WIDTH-1:0] r_g0, r_p0;
   logic             r_c0, r_v0;
   logic             r_vo, r_cout, r_ovf;
   logic [WIDTH-1:0] r_sum;

   logic [LEVELS:1][WIDTH-1:0] w_gi, w_pi, w_bi, w_go, w_po;
   logic [LEVELS:1]            w_ci, w_vi;

   logic [WIDTH-1:0] w_c, w_sum;

   assign w_adv    = !r_vo || out_ready;
   assign in_ready = w_adv;
   assign w_bx     = sub ? ~b : b;

   // stage 0 valid bit: a bubble enters whenever no beat is offered
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_v0 <= 1'b0;
      else if (w_adv)
         r_v0 <= in_valid;
   end

   // stage 0 data: bitwise generate/propagate and effective carry-in
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_g0 <= a & w_bx;
         r_p0 <= a ^ w_bx;
         r_c0 <= sub | cin;
      end
   end

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam bit UP = (l <= LG);
      localparam int K  = UP ? (l - 1) : (2*LG - 1 - l);
      localparam int S  = 1 << K;

      if (l == 1) begin : g_in0
         // carry-in sits at position -1 (g=c0, p=1), merged into bit 0
         assign w_gi[l] = {r_g0[WIDTH-1:1], r_g0[0] | (r_p0[0] & r_c0)};
         assign w_pi[l] = r_p0;
         assign w_bi[l] = r_p0;
         assign w_ci[l] = r_c0;
         assign w_vi[l] = r_v0;
      end else if (((l - 1) % REG_EVERY) == 0) begin : g_bank
         logic [WIDTH-1:0] r_g, r_p, r_b;
         logic             r_c, r_v;

         // bank valid bit shifts only when the pipe advances
         always_ff @(posedge clk) begin
            if (!rst_n)
               r_v <= 1'b0;
            else if (w_adv)
               r_v <= w_vi[l-1];
         end

         // bank data: partial prefixes plus carried p and c0
         always_ff @(posedge clk) begin
            if (w_adv) begin
               r_g <= w_go[l-1];
               r_p <= w_po[l-1];
               r_b <= w_bi[l-1];
               r_c <= w_ci[l-1];
            end
         end

         assign w_gi[l] = r_g;
         assign w_pi[l] = r_p;
         assign w_bi[l] = r_b;
         assign w_ci[l] = r_c;
         assign w_vi[l] = r_v;
      end else begin : g_wire
         assign w_gi[l] = w_go[l-1];
         assign w_pi[l] = w_po[l-1];
         assign w_bi[l] = w_bi[l-1];
         assign w_ci[l] = w_ci[l-1];
         assign w_vi[l] = w_vi[l-1];
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (UP ? ((i % (2*S)) == (2*S - 1))
                : ((((i + 1) % (2*S)) == S) && (i > S))) begin : g_op
            assign w_go[l][i] = w_gi[l][i] | (w_pi[l][i] & w_gi[l][i-S]);
            assign w_po[l][i] = w_pi[l][i] & w_pi[l][i-S];
         end else begin : g_pass
            assign w_go[l][i] = w_gi[l][i];
            assign w_po[l][i] = w_pi[l][i];
         end
      end
   end

   assign w_c   = w_go[LEVELS];
   assign w_sum = w_bi[LEVELS] ^ {w_c[WIDTH-2:0], w_ci[LEVELS]};

   // output bank: results forced to zero for bubbles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vo   <= 1'b0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_adv) begin
         r_vo   <= w_vi[LEVELS];
         r_sum  <= w_vi[LEVELS] ? w_sum : '0;
         r_cout <= w_vi[LEVELS] & w_c[WIDTH-1];
         r_ovf  <= w_vi[LEVELS] & (w_c[WIDTH-1] ^ w_c[WIDTH-2]);
      end
   end

   assign out_valid = r_vo;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder.
// Main 8-bit instance plus a width/REG_EVERY sweep.
module tb_pipelined_prefix_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endfunction

   // plain arithmetic reference: {ovf, cout, sum zero-extended to 64}
   function automatic logic [65:0] ref_add(int w, logic [63:0] x, logic [63:0] y,
                                           logic ci, logic s);
      logic [64:0] mask, xx, bb, full;
      logic [63:0] r;
      logic        co, ov;
      mask = (65'd1 << w) - 65'd1;
      xx   = {1'b0, x} & mask;
      bb   = s ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
      full = xx + bb + {64'h0, (s | ci)};
      r    = full[63:0] & mask[63:0];
      co   = full[w];
      ov   = (xx[w-1] == bb[w-1]) && (r[w-1] != xx[w-1]);
      return {ov, co, r};
   endfunction

   // ---------------- main instance: WIDTH=8, REG_EVERY=2 ----------------
   localparam int LAT = 4;

   logic       rst_n, in_valid, in_ready, cin, sub;
   logic       out_valid, out_ready, cout, ovf;
   logic [7:0] a, b, sum;
   logic       exact_lat;
   int         n_res = 0;

   pipelined_prefix_adder #(.WIDTH(8), .REG_EVERY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   typedef struct {
      logic [65:0] e;
      int          t;
   } item_t;

   item_t       q[$];
   logic        seen = 1'b0;
   logic        hv   = 1'b0;
   logic [65:0] hold_val;
   logic [65:0] act;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         seen = 1'b0;
         hv   = 1'b0;
      end else begin
         check("in_ready", in_ready, !out_valid || out_ready);
         if (!out_valid) begin
            check("idle_zero", {ovf, cout, sum}, 10'h0);
            hv = 1'b0;
         end else if (q.size() == 0) begin
            check("spurious", out_valid, 1'b0);
         end else begin
            act = {ovf, cout, 56'h0, sum};
            if (hv) check("hold", act, hold_val);
            if (!seen) begin
               seen = 1'b1;
               if (exact_lat) check("latency", cyc - q[0].t, LAT);
               else check("latency_min", (cyc - q[0].t) >= LAT, 1'b1);
            end
            check("result", act, q[0].e);
            hv       = !out_ready;
            hold_val = act;
            if (out_ready) begin
               void'(q.pop_front());
               seen = 1'b0;
               n_res++;
            end
         end
         if (in_valid && in_ready)
            q.push_back('{ref_add(8, {56'h0, a}, {56'h0, b}, cin, sub), cyc});
      end
   end

   task automatic single(string nm, logic [7:0] ta, logic [7:0] tb,
                         logic tc, logic ts, logic [65:0] e);
      @(posedge clk) #1;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk) #1;
      in_valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k < LAT) check({nm, "_early"}, out_valid, 1'b0);
      end
      check({nm, "_valid"}, out_valid, 1'b1);
      check({nm, "_value"}, {ovf, cout, 56'h0, sum}, e);
   endtask

   task automatic drain(string nm);
      for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
      check({nm, "_drained"}, q.size(), 0);
   endtask

   // ---------------- sweep instances ----------------
   function automatic int cfg_w(int j);
      case (j)
         0, 1:    return 4;
         2, 3:    return 32;
         default: return 64;
      endcase
   endfunction

   function automatic int cfg_r(int j);
      case (j)
         1:       return 3;
         3:       return 9;
         5:       return 11;
         default: return 1;
      endcase
   endfunction

   for (genvar j = 0; j < 6; j++) begin : g_sw
      localparam int W  = cfg_w(j);
      localparam int R  = cfg_r(j);
      localparam int LV = 2*$clog2(W) - 1;
      localparam int LT = (LV + R - 1) / R + 1;

      logic         s_rst_n, s_iv, s_ir, s_cin, s_sub, s_ov, s_or, s_co, s_of;
      logic [W-1:0] s_a, s_b, s_sum;
      logic         done = 1'b0;
      int           nres = 0;
      item_t        sq[$];

      pipelined_prefix_adder #(.WIDTH(W), .REG_EVERY(R)) u_dut (
         .clk(clk), .rst_n(s_rst_n),
         .in_valid(s_iv), .in_ready(s_ir),
         .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
         .out_valid(s_ov), .out_ready(s_or),
         .sum(s_sum), .cout(s_co), .ovf(s_of)
      );

      always @(negedge clk) begin
         if (s_rst_n) begin
            if (s_ov) begin
               if (sq.size() == 0) begin
                  check($sformatf("sw%0d_spurious", j), s_ov, 1'b0);
               end else begin
                  check($sformatf("sw%0d_latency", j), cyc - sq[0].t, LT);
                  check($sformatf("sw%0d_result", j),
                        {s_of, s_co, 64'(s_sum)}, sq[0].e);
                  void'(sq.pop_front());
                  nres++;
               end
            end
            if (s_iv && s_ir)
               sq.push_back('{ref_add(W, 64'(s_a), 64'(s_b), s_cin, s_sub), cyc});
         end
      end

      initial begin
         logic [63:0] tmp;
         s_rst_n = 1'b0; s_iv = 1'b0; s_or = 1'b1;
         s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
         repeat (2) @(posedge clk);
         #1 s_rst_n = 1'b1;
         for (int k = 0; k < 20; k++) begin
            tmp   = {$urandom, $urandom};
            s_a   = tmp[W-1:0];
            tmp   = {$urandom, $urandom};
            s_b   = tmp[W-1:0];
            s_cin = 1'($urandom % 2);
            s_sub = 1'($urandom % 2);
            s_iv  = 1'b1;
            @(posedge clk) #1;
         end
         s_iv = 1'b0;
         repeat (LT + 4) @(posedge clk);
         check($sformatf("sw%0d_count", j), nres, 20);
         done = 1'b1;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int base;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0; exact_lat = 1'b1;

      check("model_7f01", ref_add(8, 64'h7F, 64'h01, 1'b0, 1'b0), {1'b1, 1'b0, 64'h80});
      check("model_sub01", ref_add(8, 64'h00, 64'h01, 1'b0, 1'b1), {1'b0, 1'b0, 64'hFF});
      check("model_ffff", ref_add(8, 64'hFF, 64'hFF, 1'b1, 1'b0), {1'b0, 1'b1, 64'hFF});
      check("model_w4sub", ref_add(4, 64'h8, 64'h1, 1'b0, 1'b1), {1'b1, 1'b1, 64'h7});

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_outputs", {ovf, cout, sum}, 10'h0);
      @(posedge clk) #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);

      single("d7f", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 64'h80});
      single("dsub", 8'h00, 8'h01, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFF});
      single("dff", 8'hFF, 8'hFF, 1'b1, 1'b0, {1'b0, 1'b1, 64'hFF});
      drain("directed");

      base = n_res;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk) #1;
         a = 8'($urandom); b = 8'($urandom);
         cin = 1'($urandom % 2); sub = 1'($urandom % 2);
         in_valid = 1'b1;
      end
      @(posedge clk) #1 in_valid = 1'b0;
      drain("b2b");
      check("b2b_count", n_res - base, 100);

      exact_lat = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk) #1;
         a = 8'($urandom); b = 8'($urandom);
         cin = 1'($urandom % 2); sub = 1'($urandom % 2);
         in_valid  = 1'($urandom % 2);
         out_ready = 1'($urandom % 2);
      end
      @(posedge clk) #1;
      in_valid = 1'b0; out_ready = 1'b1;
      drain("random");
      @(posedge clk) #1 exact_lat = 1'b1;

      for (int k = 0; k < 3; k++) begin
         @(posedge clk) #1;
         a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      end
      @(posedge clk) #1 rst_n = 1'b0;
      @(posedge clk) #1;
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 12; k++) begin
         check("midrst_quiet", out_valid, 1'b0);
         @(negedge clk);
      end

      for (int k = 0; k < 2000 && !(g_sw[0].done && g_sw[1].done &&
           g_sw[2].done && g_sw[3].done && g_sw[4].done && g_sw[5].done); k++)
         @(posedge clk);
      check("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done &&
            g_sw[3].done && g_sw[4].done && g_sw[5].done, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
